// File: rtl/uart_rx_sampler_pkg.sv
// Shared definitions for the UART receive sampler: FSM states, parity modes
// and small helpers used to size counters and judge the parity bit.
package uart_rx_sampler_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_DATA       = 3'd2,
        S_PARITY     = 3'd3,
        S_STOP       = 3'd4,
        S_BREAK_WAIT = 3'd5
    } rx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // data_xor is the XOR of all data bits; returns 1 when the received
    // parity bit disagrees with the selected parity mode.
    function automatic logic parity_error(input logic data_xor, input logic par_bit,
                                          input int mode);
        return (mode == PARITY_ODD) ? ~(data_xor ^ par_bit) : (data_xor ^ par_bit);
    endfunction

endpackage

// File: rtl/uart_rx_sampler_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit. The reset value
// is a parameter so idle-high lines (UART rx) come out of reset as idle.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the raw input through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receiver driven by an oversampling strobe (s_tick). Samples the
// middle of every bit, shifts data LSB first, checks optional parity and the
// stop bit, and reports each word with a one-clock rx_done_tick. A line held
// low for a whole frame (break) is reported once and the receiver then waits
// for the line to return high before looking for the next start bit.
module uart_rx_sampler
    import uart_rx_sampler_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int OS      = 16,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err,
    output logic            busy
);

    localparam int TW = $clog2(max_int(OS, SB_TICK));
    localparam int NW = $clog2(DBIT);

    localparam logic [TW-1:0] T_MID  = TW'(OS / 2 - 1);
    localparam logic [TW-1:0] T_BIT  = TW'(OS - 1);
    localparam logic [TW-1:0] T_STOP = TW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    logic            rx_s;
    rx_state_e       state_q;
    logic [TW-1:0]   t_q;
    logic [NW-1:0]   n_q;
    logic [DBIT-1:0] b_q;
    logic            perr_q;
    logic [DBIT-1:0] dout_q;
    logic            done_q;
    logic            ferr_q;
    logic            parity_err_q;

    sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    // Receive FSM with its counters, shift register and registered outputs.
    // NOTE: every register here is updated with non-blocking assignments so all
    // decisions in one clock see the values from before that edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            t_q          <= '0;
            n_q          <= '0;
            b_q          <= '0;
            perr_q       <= 1'b0;
            dout_q       <= '0;
            done_q       <= 1'b0;
            ferr_q       <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_q <= S_START;
                        t_q     <= '0;
                    end
                end
                S_START: begin
                    if (s_tick) begin
                        if (t_q == T_MID) begin
                            if (!rx_s) begin
                                state_q <= S_DATA;
                                t_q     <= '0;
                                n_q     <= '0;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end else begin
                            t_q <= t_q + TW'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (s_tick) begin
                        if (t_q == T_BIT) begin
                            b_q <= {rx_s, b_q[DBIT-1:1]};
                            t_q <= '0;
                            if (n_q == N_LAST) begin
                                state_q <= (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
                            end else begin
                                n_q <= n_q + NW'(1);
                            end
                        end else begin
                            t_q <= t_q + TW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (s_tick) begin
                        if (t_q == T_BIT) begin
                            perr_q  <= parity_error(^b_q, rx_s, PARITY);
                            t_q     <= '0;
                            state_q <= S_STOP;
                        end else begin
                            t_q <= t_q + TW'(1);
                        end
                    end
                end
                S_STOP: begin
                    if (s_tick) begin
                        if (t_q == T_STOP) begin
                            dout_q       <= b_q;
                            ferr_q       <= ~rx_s;
                            parity_err_q <= (PARITY != PARITY_NONE) ? perr_q : 1'b0;
                            done_q       <= 1'b1;
                            // All-zero data with a low stop bit is a break.
                            state_q      <= (!rx_s && (b_q == '0)) ? S_BREAK_WAIT : S_IDLE;
                        end else begin
                            t_q <= t_q + TW'(1);
                        end
                    end
                end
                S_BREAK_WAIT: begin
                    if (rx_s) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign parity_err   = parity_err_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler. One instance runs 8N1, a second runs
// 8E1. Stimulus tasks push the expected word before driving each frame; a
// monitor per instance pops and compares whenever rx_done_tick is seen.
module tb_uart_rx_sampler;

    localparam int TICK_DIV = 4;              // clk per s_tick
    localparam int BIT_CLKS = 16 * TICK_DIV;  // clk per bit period

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic [7:0] dout0, dout1;
    logic       done0, done1, ferr0, ferr1, perr0, perr1, busy0, busy1;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    uart_rx_sampler #(.DBIT(8), .OS(16), .SB_TICK(16), .PARITY(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx0),
        .dout(dout0), .rx_done_tick(done0), .frame_err(ferr0),
        .parity_err(perr0), .busy(busy0)
    );

    uart_rx_sampler #(.DBIT(8), .OS(16), .SB_TICK(16), .PARITY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx1),
        .dout(dout1), .rx_done_tick(done1), .frame_err(ferr1),
        .parity_err(perr1), .busy(busy1)
    );

    always #5 clk = ~clk;

    // Oversampling strobe: one clk wide every TICK_DIV clocks.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            cnt = (cnt == TICK_DIV - 1) ? 0 : cnt + 1;
            s_tick = (cnt == 0);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_rx(input int line, input logic v);
        if (line == 0) rx0 = v;
        else           rx1 = v;
    endtask

    // Hold a line at value v for n clocks.
    task automatic drive_bit(input int line, input logic v, input int n);
        @(negedge clk);
        set_rx(line, v);
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic send_frame(input int line, input logic [7:0] d, input bit has_par,
                              input bit par, input bit stop_low);
        drive_bit(line, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(line, d[i], BIT_CLKS);
        if (has_par) drive_bit(line, par, BIT_CLKS);
        if (stop_low) begin
            // Low past the stop mid-point, then back to idle.
            drive_bit(line, 1'b0, 48);
            drive_bit(line, 1'b1, BIT_CLKS - 48);
        end else begin
            drive_bit(line, 1'b1, BIT_CLKS);
        end
    endtask

    task automatic push0(input logic [7:0] d, input logic fe, input logic pe);
        exp_t e;
        e.d = d; e.fe = fe; e.pe = pe;
        q0.push_back(e);
    endtask

    task automatic push1(input logic [7:0] d, input logic fe, input logic pe);
        exp_t e;
        e.d = d; e.fe = fe; e.pe = pe;
        q1.push_back(e);
    endtask

    // Monitor for the 8N1 instance.
    initial begin
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done0 === 1'b1) begin
                if (prev) check("dut0_done_width", 2, 1);
                if (q0.size() == 0) begin
                    check("dut0_unexpected_done", 1, 0);
                end else begin
                    e = q0.pop_front();
                    check("dut0_dout", int'(dout0), int'(e.d));
                    check("dut0_frame_err", int'(ferr0), int'(e.fe));
                    check("dut0_parity_err", int'(perr0), int'(e.pe));
                end
            end
            prev = done0;
        end
    end

    // Monitor for the 8E1 instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done1 === 1'b1) begin
                if (q1.size() == 0) begin
                    check("dut1_unexpected_done", 1, 0);
                end else begin
                    e = q1.pop_front();
                    check("dut1_dout", int'(dout1), int'(e.d));
                    check("dut1_frame_err", int'(ferr1), int'(e.fe));
                    check("dut1_parity_err", int'(perr1), int'(e.pe));
                end
            end
        end
    end

    initial begin
        // Reset state.
        repeat (4) @(negedge clk);
        check("rst_dout", int'(dout0), 0);
        check("rst_done", int'(done0), 0);
        check("rst_frame_err", int'(ferr0), 0);
        check("rst_parity_err", int'(perr0), 0);
        check("rst_busy", int'(busy0), 0);
        reset_n = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);

        // Single clean frame.
        push0(8'hA5, 1'b0, 1'b0);
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);
        check("hold_dout_a5", int'(dout0), 'hA5);
        check("idle_busy", int'(busy0), 0);

        // Back-to-back frames with no idle gap.
        push0(8'h3C, 1'b0, 1'b0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        push0(8'hC3, 1'b0, 1'b0);
        send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);

        // Short low glitch: start detected, rejected at the mid-start check.
        @(negedge clk);
        rx0 = 1'b0;
        repeat (6) @(negedge clk);
        check("glitch_busy_high", int'(busy0), 1);
        repeat (6) @(negedge clk);
        rx0 = 1'b1;
        repeat (60) @(negedge clk);
        check("glitch_busy_low", int'(busy0), 0);
        check("glitch_dout_kept", int'(dout0), 'hC3);

        // Stop bit forced low: word still delivered, frame error flagged.
        push0(8'h55, 1'b1, 1'b0);
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("ferr_sticky", int'(ferr0), 1);

        // Reset in the middle of data bit 4.
        drive_bit(0, 1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, BIT_CLKS);
        drive_bit(0, 1'b0, BIT_CLKS / 2);
        check("midframe_busy", int'(busy0), 1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", int'(busy0), 0);
        check("abort_dout", int'(dout0), 0);
        check("abort_frame_err", int'(ferr0), 0);
        rx0 = 1'b1;
        repeat (10) @(negedge clk);
        reset_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        push0(8'h81, 1'b0, 1'b0);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);

        // Break: line low for 20 bit times gives exactly one zero frame.
        push0(8'h00, 1'b1, 1'b0);
        drive_bit(0, 1'b0, 20 * BIT_CLKS);
        check("break_busy_high", int'(busy0), 1);
        rx0 = 1'b1;
        repeat (6) @(negedge clk);
        check("break_busy_low", int'(busy0), 0);
        repeat (BIT_CLKS) @(negedge clk);

        // Even parity on 0x07 (three ones): parity bit 0 is wrong, 1 is right.
        push1(8'h07, 1'b0, 1'b1);
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b0);
        push1(8'h07, 1'b0, 1'b0);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b0);
        repeat (2 * BIT_CLKS) @(negedge clk);

        check("dut0_missing_done", q0.size(), 0);
        check("dut1_missing_done", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
